// File: rtl/hazard_ctrl.sv
// Read-after-write hazard scoreboard and pipeline hold/bubble control for a core without forwarding.
// Optional hazard-stall counter is enabled by defining HAZARD_STALL_CNT_EN.
module hazard_ctrl #(
  parameter int PIPE_DEPTH     = 3,
  parameter int REGFILE_BYPASS = 0,
  parameter int STALL_CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_reg1_read_i,
  input  logic [4:0]             id_reg1_addr_i,
  input  logic                   id_reg2_read_i,
  input  logic [4:0]             id_reg2_addr_i,
  input  logic                   id_wreg_i,
  input  logic [4:0]             id_wd_i,
  input  logic                   fetch_stall_i,
  output logic                   pc_hold_o,
  output logic                   ifid_hold_o,
  output logic                   ifid_bubble_o,
  output logic                   idex_bubble_o,
  output logic [PIPE_DEPTH-1:0]  pending_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  // With regfile bypass the write-cycle slot is already visible to the reader.
  localparam int CMP_SLOTS = PIPE_DEPTH - REGFILE_BYPASS;

  logic [PIPE_DEPTH-1:0] r_valid;
  logic [4:0]            r_addr [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] w_match;
  logic                  w_hazard;
  logic                  w_issue;

  always_comb begin
    w_match = '0;
    for (int i = 0; i < CMP_SLOTS; i++) begin
      w_match[i] = r_valid[i] && (r_addr[i] != 5'd0) &&
                   ((id_reg1_read_i && (r_addr[i] == id_reg1_addr_i)) ||
                    (id_reg2_read_i && (r_addr[i] == id_reg2_addr_i)));
    end
  end

  assign w_hazard = |w_match;
  assign w_issue  = !w_hazard && id_wreg_i && (id_wd_i != 5'd0);

  // The shift never stalls, so every hazard clears within CMP_SLOTS cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        r_addr[i] <= 5'd0;
      end
    end else begin
      r_valid[0] <= w_issue;
      r_addr[0]  <= id_wd_i;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_addr[i]  <= r_addr[i-1];
      end
    end
  end

  // Gated by rst so fetch_stall_i cannot leak through while reset is held.
  assign pc_hold_o     = rst && (w_hazard || fetch_stall_i);
  assign ifid_hold_o   = rst && w_hazard;
  assign ifid_bubble_o = rst && !w_hazard && fetch_stall_i;
  assign idex_bubble_o = rst && w_hazard;
  assign pending_o     = r_valid;

`ifdef HAZARD_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
